vec_mem_stage: RTL

- Memory stage directly downstream of the vector ALU; executes VLD (4'b0100) and VST (4'b0101).
- A 256-bit vector is 16 lanes × 16-bit half-floats; memory is 16-bit word-addressed with single-cycle synchronous read.
- VST serializes one lane per cycle to memory. VLD gathers 16 words into one vector and presents it for writeback.

---
 rtl/vec_mem_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vec_mem_stage.sv
// Vector memory stage: VST serializes 16 lanes to word memory, VLD gathers 16 words into one vector.
// All outputs are registered, so each memory request appears one cycle after the FSM cycle that issued it.
module vec_mem_stage #(
    parameter int         LANES  = 16,
    parameter int         LANE_W = 16,
    parameter int         ADDR_W = 16,
    parameter logic [3:0] OP_VLD = 4'b0100,
    parameter logic [3:0] OP_VST = 4'b0101
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               opcode,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LANES*LANE_W-1:0]  vec_in,
    output logic                     busy,
    output logic                     done,
    output logic [LANES*LANE_W-1:0]  vec_out,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LANE_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [LANE_W-1:0]        mem_rdata
);

    localparam int             VEC_W = LANES * LANE_W;
    localparam int             K_W   = $clog2(LANES);
    localparam logic [K_W-1:0] LAST  = K_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_TAIL = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Handshake: start/opcode are taken only on an edge where the FSM is IDLE; there is
    // no back-pressure, so a start seen in any other state is simply dropped.
    state_t              state, state_n;
    logic [K_W-1:0]      k, k_n;
    logic                accept;
    logic [ADDR_W-1:0]   base_q;
    logic [VEC_W-1:0]    vec_q;
    logic                is_load;
    logic [VEC_W-1:0]    gather, gather_n;
    logic [K_W-1:0]      re_lane, cap_lane;
    logic                cap_valid;

    logic                busy_n, done_n, we_n, re_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [LANE_W-1:0]   wdata_n;
    logic [VEC_W-1:0]    vec_out_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end
    end

    // Read data lands one cycle after the registered mem_re, tagged with the lane that issued it.
    always_comb begin
        gather_n = gather;
        if (cap_valid) begin
            gather_n[cap_lane*LANE_W +: LANE_W] = mem_rdata;
        end
    end

    always_comb begin
        state_n   = state;
        k_n       = k;
        accept    = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        we_n      = 1'b0;
        re_n      = 1'b0;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        vec_out_n = vec_out;
        case (state)
            IDLE: begin
                if (start && opcode == OP_VST) begin
                    accept  = 1'b1;
                    k_n     = '0;
                    state_n = STORE;
                end else if (start && opcode == OP_VLD) begin
                    accept  = 1'b1;
                    k_n     = '0;
                    state_n = LOAD;
                end
            end
            STORE: begin
                busy_n  = 1'b1;
                we_n    = 1'b1;
                addr_n  = base_q + ADDR_W'(k);
                wdata_n = vec_q[k*LANE_W +: LANE_W];
                k_n     = k + K_W'(1);
                if (k == LAST) state_n = DONE;
            end
            LOAD: begin
                busy_n = 1'b1;
                re_n   = 1'b1;
                addr_n = base_q + ADDR_W'(k);
                k_n    = k + K_W'(1);
                if (k == LAST) state_n = LOAD_TAIL;
            end
            LOAD_TAIL: begin
                busy_n  = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                done_n = 1'b1;
                // The last lane is still in flight here, so publish the merged gather.
                if (is_load) vec_out_n = gather_n;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            vec_q     <= '0;
            is_load   <= 1'b0;
            gather    <= '0;
            re_lane   <= '0;
            cap_lane  <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vec_out   <= '0;
        end else begin
            if (accept) begin
                base_q  <= base_addr;
                is_load <= (opcode == OP_VLD);
                if (opcode == OP_VST) vec_q <= vec_in;
            end
            gather    <= gather_n;
            re_lane   <= k;
            cap_lane  <= re_lane;
            cap_valid <= mem_re;
            busy      <= busy_n;
            done      <= done_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            vec_out   <= vec_out_n;
        end
    end

endmodule
